lsu_bus_bridge: RTL

Load/store unit between the single-cycle datapath and a multi-cycle data bus. It takes the datapath's memory-access request (ALU address, store data, access size) and converts it into a word-aligned bus transaction with byte enables and a req/ack handshake. It stalls the core until the transaction completes, then returns the read word shifted to byte lane 0. The datapath's load-extension logic then sign- or zero-extends that word.

---
 rtl/lsu_bus_bridge.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
//
// Purpose:
//   Load/store unit that sits between the single-cycle datapath and a
//   multi-cycle data bus. A datapath memory access (byte/half/word) becomes a
//   word-aligned bus transaction with byte enables and a req/ack handshake.
//   The core is stalled until the transaction completes. The read word is
//   returned shifted down to byte lane 0; sign/zero extension happens later in
//   the datapath.
//
// Optional feature:
//   LSU_TIMEOUT_EN - when defined, a REQ that sees no ack within
//                    TIMEOUT_CYCLES cycles is aborted and reported on o_busErr.
//                    When undefined, REQ waits for ack indefinitely and
//                    o_busErr is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum REQ cycles before the abort (1..65535)
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_memRead          load request from the datapath
//   i_memWrite         store request from the datapath
//   i_memSize          00 byte, 01 half, 10 word, 11 illegal
//   i_addr             byte address
//   i_writeData        store data, relevant bytes in the low bits
//   o_readData         loaded word shifted to lane 0 (valid in DONE)
//   o_stall            hold PC / suppress register write (combinational)
//   o_misaligned       misaligned or illegal access (DONE only)
//   o_busErr           bus timeout (DONE only)
//   o_busReq           bus request
//   o_busWe            bus write strobe (1 = write)
//   o_busAddr          word-aligned bus address
//   o_busWdata         lane-replicated store data
//   o_busByteEn        active byte lanes
//   i_busAck           bus transaction complete, i_busRdata valid
//   i_busRdata         bus read word
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    output logic [31:0] o_readData,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_busErr,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic [31:0] o_busAddr,
    output logic [31:0] o_busWdata,
    output logic [3:0]  o_busByteEn,
    input  logic        i_busAck,
    input  logic [31:0] i_busRdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Catch an out-of-range timeout at elaboration time.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("lsu_bus_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_byte_en_q, bus_byte_en_d;
    logic [31:0] read_data_q, read_data_d;
    logic        misaligned_q, misaligned_d;
    // Byte offset of the access, kept so the read word can be shifted to
    // lane 0 on the ack edge independent of what the core drives then.
    logic [1:0]  lane_q, lane_d;

    logic        access;
    logic        aligned;
    logic [3:0]  lane_en;
    logic [31:0] lane_wdata;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic        timeout_hit;

    assign timeout_hit = (timeout_cnt_q == TIMEOUT_LAST);
`endif

    assign access = i_memRead | i_memWrite;

    // Alignment check plus byte-lane enables and replicated store data.
    // Replicating the store bytes across the word lets the bus pick the
    // right lane purely from the byte enables.
    always_comb begin
        aligned    = 1'b0;
        lane_en    = 4'b0000;
        lane_wdata = i_writeData;
        case (i_memSize)
            2'b00: begin
                aligned    = 1'b1;
                lane_en    = 4'b0001 << i_addr[1:0];
                lane_wdata = {4{i_writeData[7:0]}};
            end
            2'b01: begin
                aligned    = ~i_addr[0];
                lane_en    = i_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{i_writeData[15:0]}};
            end
            2'b10: begin
                aligned    = (i_addr[1:0] == 2'b00);
                lane_en    = 4'b1111;
                lane_wdata = i_writeData;
            end
            default: begin
                aligned    = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic. Bus outputs are only loaded on
    // the IDLE->REQ edge, which keeps them stable for the whole request.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_byte_en_d = bus_byte_en_q;
        read_data_d   = read_data_q;
        misaligned_d  = misaligned_q;
        lane_d        = lane_q;
`ifdef LSU_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
        bus_err_d     = bus_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        state_d       = ST_REQ;
                        bus_req_d     = 1'b1;
                        bus_we_d      = i_memWrite;
                        bus_addr_d    = {i_addr[31:2], 2'b00};
                        bus_wdata_d   = lane_wdata;
                        bus_byte_en_d = lane_en;
                        lane_d        = i_addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        timeout_cnt_d = 16'd0;
`endif
                    end else begin
                        state_d      = ST_DONE;
                        misaligned_d = 1'b1;
                        read_data_d  = 32'd0;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the same edge as the timeout is a normal completion.
                if (i_busAck) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    read_data_d = bus_we_q ? 32'd0 : (i_busRdata >> {lane_q, 3'b000});
                end
`ifdef LSU_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    read_data_d = 32'd0;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                misaligned_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                bus_err_d    = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            bus_byte_en_q <= 4'd0;
            read_data_q   <= 32'd0;
            misaligned_q  <= 1'b0;
            lane_q        <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            timeout_cnt_q <= 16'd0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_byte_en_q <= bus_byte_en_d;
            read_data_q   <= read_data_d;
            misaligned_q  <= misaligned_d;
            lane_q        <= lane_d;
`ifdef LSU_TIMEOUT_EN
            timeout_cnt_q <= timeout_cnt_d;
            bus_err_q     <= bus_err_d;
`endif
        end
    end

    // The stall drops in DONE so the core commits on the closing edge.
    assign o_stall      = access & (state_q != ST_DONE);
    assign o_readData   = read_data_q;
    assign o_misaligned = misaligned_q;
    assign o_busReq     = bus_req_q;
    assign o_busWe      = bus_we_q;
    assign o_busAddr    = bus_addr_q;
    assign o_busWdata   = bus_wdata_q;
    assign o_busByteEn  = bus_byte_en_q;
`ifdef LSU_TIMEOUT_EN
    assign o_busErr     = bus_err_q;
`else
    assign o_busErr     = 1'b0;
`endif

endmodule
